sdrc_app_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single application request/data port of the SDRAM controller among NREQ masters.

---
 rtl/sdrc_app_arbiter.sv | 142 ++++++++++++++
 tb/tb_sdrc_app_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_app_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller application port among
// NREQ masters. A grant is held for the whole burst, then priority rotates.
module sdrc_app_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned APP_AW = 30,
  parameter int unsigned APP_DW = 32,
  parameter int unsigned APP_BW = 4,
  parameter int unsigned APP_RW = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          m_req,
  input  logic [NREQ*APP_AW-1:0]   m_addr,
  input  logic [NREQ*APP_RW-1:0]   m_len,
  input  logic [NREQ-1:0]          m_wr_n,
  input  logic [NREQ*APP_DW-1:0]   m_wr_data,
  input  logic [NREQ*APP_BW-1:0]   m_wr_en_n,
  output logic [NREQ-1:0]          m_ack,
  output logic [NREQ-1:0]          m_wr_next,
  output logic [NREQ-1:0]          m_rd_valid,
  output logic [APP_DW-1:0]        m_rd_data,
  output logic [1:0]               grant_id,
  output logic                     busy,
  output logic                     app_sdr_req,
  output logic [APP_AW-1:0]        app_req_addr,
  output logic [APP_RW-1:0]        app_req_len,
  output logic                     app_req_wr_n,
  input  logic                     app_req_ack,
  output logic [APP_DW-1:0]        app_wr_data,
  output logic [APP_BW-1:0]        app_wr_en_n,
  input  logic                     app_wr_next,
  input  logic [APP_DW-1:0]        app_rd_data,
  input  logic                     app_rd_valid
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t              state;
  logic [APP_RW-1:0]   beat_cnt;

  logic                pick_found;
  logic [1:0]          pick_id;
  logic [APP_AW-1:0]   pick_addr;
  logic [APP_RW-1:0]   pick_len;
  logic                pick_wr_n;

  logic [NREQ-1:0]     gnt_onehot;
  logic [APP_DW-1:0]   gnt_wr_data;
  logic [APP_BW-1:0]   gnt_wr_en_n;
  logic                beat;

  // Round-robin search: first requester after the last granted master.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = grant_id;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!pick_found && m_req[(32'(grant_id) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_id    = 2'((32'(grant_id) + k) % NREQ);
      end
    end
  end

  // Request fields of the winning master, and data steering of the granted one.
  always_comb begin
    pick_addr   = '0;
    pick_len    = '0;
    pick_wr_n   = 1'b0;
    gnt_onehot  = '0;
    gnt_wr_data = '0;
    gnt_wr_en_n = '1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_id == 2'(i)) begin
        pick_addr = m_addr[i*APP_AW +: APP_AW];
        pick_len  = m_len[i*APP_RW +: APP_RW];
        pick_wr_n = m_wr_n[i];
      end
      if (grant_id == 2'(i)) begin
        gnt_onehot[i] = 1'b1;
        gnt_wr_data   = m_wr_data[i*APP_DW +: APP_DW];
        gnt_wr_en_n   = m_wr_en_n[i*APP_BW +: APP_BW];
      end
    end
  end

  // A beat is a handshake of the burst's own direction while transferring.
  always_comb begin
    beat = (state == XFER) && (app_req_wr_n ? app_rd_valid : app_wr_next);
  end

  // Handshake routing back to the granted master only.
  always_comb begin
    m_ack       = (state == REQ && app_req_ack) ? gnt_onehot : '0;
    m_wr_next   = (state == XFER && !app_req_wr_n && app_wr_next) ? gnt_onehot : '0;
    m_rd_valid  = (state == XFER && app_req_wr_n && app_rd_valid) ? gnt_onehot : '0;
    m_rd_data   = app_rd_data;
    app_wr_data = gnt_wr_data;
    app_wr_en_n = (state == XFER && !app_req_wr_n) ? gnt_wr_en_n : '1;
    busy        = (state != IDLE);
  end

  // Arbitration FSM with registered request fields and burst beat counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant_id     <= 2'(NREQ - 1);
      app_sdr_req  <= 1'b0;
      app_req_addr <= '0;
      app_req_len  <= '0;
      app_req_wr_n <= 1'b0;
      beat_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id     <= pick_id;
            app_req_addr <= pick_addr;
            app_req_len  <= pick_len;
            app_req_wr_n <= pick_wr_n;
            app_sdr_req  <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (app_req_ack) begin
            app_sdr_req <= 1'b0;
            beat_cnt    <= app_req_len;
            state       <= (app_req_len == '0) ? IDLE : XFER;
          end
        end
        XFER: begin
          if (beat && beat_cnt != '0) begin
            beat_cnt <= beat_cnt - APP_RW'(1);
            if (beat_cnt == APP_RW'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdrc_app_arbiter.sv
// Scoreboard bench for sdrc_app_arbiter: expected grants are queued as
// requests are posted and popped when the arbiter acknowledges a master.
module tb_sdrc_app_arbiter;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned APP_AW = 30;
  localparam int unsigned APP_DW = 32;
  localparam int unsigned APP_BW = 4;
  localparam int unsigned APP_RW = 9;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NREQ-1:0]        m_req;
  logic [NREQ*APP_AW-1:0] m_addr;
  logic [NREQ*APP_RW-1:0] m_len;
  logic [NREQ-1:0]        m_wr_n;
  logic [NREQ*APP_DW-1:0] m_wr_data;
  logic [NREQ*APP_BW-1:0] m_wr_en_n;
  logic [NREQ-1:0]        m_ack;
  logic [NREQ-1:0]        m_wr_next;
  logic [NREQ-1:0]        m_rd_valid;
  logic [APP_DW-1:0]      m_rd_data;
  logic [1:0]             grant_id;
  logic                   busy;
  logic                   app_sdr_req;
  logic [APP_AW-1:0]      app_req_addr;
  logic [APP_RW-1:0]      app_req_len;
  logic                   app_req_wr_n;
  logic                   app_req_ack;
  logic [APP_DW-1:0]      app_wr_data;
  logic [APP_BW-1:0]      app_wr_en_n;
  logic                   app_wr_next;
  logic [APP_DW-1:0]      app_rd_data;
  logic                   app_rd_valid;

  always #5 clk = ~clk;

  sdrc_app_arbiter #(
    .NREQ(NREQ), .APP_AW(APP_AW), .APP_DW(APP_DW), .APP_BW(APP_BW), .APP_RW(APP_RW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_req(m_req), .m_addr(m_addr), .m_len(m_len), .m_wr_n(m_wr_n),
    .m_wr_data(m_wr_data), .m_wr_en_n(m_wr_en_n),
    .m_ack(m_ack), .m_wr_next(m_wr_next), .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data),
    .grant_id(grant_id), .busy(busy),
    .app_sdr_req(app_sdr_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n), .app_wr_next(app_wr_next),
    .app_rd_data(app_rd_data), .app_rd_valid(app_rd_valid)
  );

  typedef struct {
    int unsigned       m;
    logic [APP_AW-1:0] addr;
    logic [APP_RW-1:0] len;
    logic              wr_n;
  } exp_t;

  exp_t sb[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [APP_AW-1:0] cfg_addr [NREQ];
  logic [APP_RW-1:0] cfg_len  [NREQ];
  logic              cfg_wr_n [NREQ];
  logic [APP_DW-1:0] wdat     [NREQ];
  logic [APP_BW-1:0] wen      [NREQ];
  int unsigned       pend     [NREQ];
  logic [APP_DW-1:0] rd_drv;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic config_master(input int unsigned i, input logic [APP_AW-1:0] addr,
                               input logic [APP_RW-1:0] len, input logic wr_n);
    cfg_addr[i] = addr;
    cfg_len[i]  = len;
    cfg_wr_n[i] = wr_n;
    m_addr[i*APP_AW +: APP_AW] = addr;
    m_len[i*APP_RW +: APP_RW]  = len;
    m_wr_n[i] = wr_n;
  endtask

  task automatic expect_grant(input int unsigned i);
    sb.push_back('{i, cfg_addr[i], cfg_len[i], cfg_wr_n[i]});
  endtask

  task automatic post(input int unsigned i, input int unsigned cnt);
    pend[i]  = cnt;
    m_req[i] = 1'b1;
  endtask

  // Converter side of one burst: accept the request, then supply the beats.
  task automatic serve(input bit early, input bit gappy, input int abort_at);
    bit              got = 1'b0;
    logic [NREQ-1:0] acked;
    int unsigned     len;
    bit              wr;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      got = app_sdr_req;
    end
    if (!got) begin
      check("req_timeout", app_sdr_req, 1);
      return;
    end
    len = app_req_len;
    wr  = !app_req_wr_n;
    app_req_ack = 1'b1;
    app_wr_next = early;
    @(negedge clk);
    acked = m_ack;
    @(posedge clk); #1;
    app_req_ack = 1'b0;
    app_wr_next = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (acked[i] && pend[i] != 0) pend[i]--;
      m_req[i] = (pend[i] != 0);
    end
    if (len == 0) begin
      check("len0_idle", busy, 0);
      return;
    end
    for (int unsigned b = 0; b < len; b++) begin
      if (int'(b) == abort_at) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_req", app_sdr_req, 0);
        check("rst_gid", grant_id, NREQ - 1);
        check("rst_len", app_req_len, 0);
        reset_n = 1'b1;
        return;
      end
      if (gappy) begin
        for (int unsigned g = 0; g < b % 3; g++) begin
          if (wr) app_rd_valid = 1'b1; else app_wr_next = 1'b1;
          @(posedge clk); #1;
          app_rd_valid = 1'b0;
          app_wr_next  = 1'b0;
        end
      end
      rd_drv      = $urandom;
      app_rd_data = rd_drv;
      if (wr) app_wr_next = 1'b1; else app_rd_valid = 1'b1;
      @(posedge clk); #1;
      app_rd_valid = 1'b0;
      app_wr_next  = 1'b0;
    end
    check("end_idle", busy, 0);
  endtask

  // Monitor: pops the scoreboard on each ack and audits the following burst.
  exp_t        cur;
  logic        active;
  int unsigned beats;
  logic        prev_busy;
  logic        idle_seen;

  always @(negedge clk) begin
    if (!reset_n) begin
      active    = 1'b0;
      prev_busy = 1'b0;
      idle_seen = 1'b1;
      beats     = 0;
    end else begin
      if (!busy) begin
        idle_seen = 1'b1;
        check("wen_idle", app_wr_en_n, {APP_BW{1'b1}});
      end
      if (m_ack != '0) begin
        check("ack_onehot", $countones(m_ack), 1);
        check("gap", idle_seen, 1);
        idle_seen = 1'b0;
        if (sb.size() == 0) begin
          check("sb_underflow", m_ack, 0);
        end else begin
          cur = sb.pop_front();
          check("ack_who", m_ack, NREQ'(1) << cur.m);
          check("grant_id", grant_id, cur.m);
          check("req_addr", app_req_addr, cur.addr);
          check("req_len", app_req_len, cur.len);
          check("req_wr_n", app_req_wr_n, cur.wr_n);
          active = 1'b1;
          beats  = 0;
        end
      end
      if ((m_wr_next | m_rd_valid) != '0) begin
        if (active) begin
          beats++;
          check("wr_next", m_wr_next, cur.wr_n ? 0 : (NREQ'(1) << cur.m));
          check("rd_valid", m_rd_valid, cur.wr_n ? (NREQ'(1) << cur.m) : 0);
          if (cur.wr_n) begin
            check("rd_data", m_rd_data, rd_drv);
          end else begin
            check("wr_data", app_wr_data, wdat[cur.m]);
            check("wr_en_n", app_wr_en_n, wen[cur.m]);
          end
        end else begin
          check("stray", m_wr_next | m_rd_valid, 0);
        end
      end
      if (prev_busy && !busy && active) begin
        check("beats", beats, cur.len);
        active = 1'b0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    m_req        = '0;
    m_addr       = '0;
    m_len        = '0;
    m_wr_n       = '0;
    app_req_ack  = 1'b0;
    app_wr_next  = 1'b0;
    app_rd_valid = 1'b0;
    app_rd_data  = '0;
    rd_drv       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      wdat[i] = 32'hC0DE_0000 + i * 32'h1111;
      wen[i]  = (i == 0) ? 4'b0000 : 4'b1010;
      m_wr_data[i*APP_DW +: APP_DW] = wdat[i];
      m_wr_en_n[i*APP_BW +: APP_BW] = wen[i];
      pend[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant_id, NREQ - 1);
    check("rst_busy0", busy, 0);
    check("rst_sdr_req", app_sdr_req, 0);
    check("rst_addr", app_req_addr, 0);
    check("rst_len0", app_req_len, 0);
    check("rst_ack", m_ack, 0);
    check("rst_wnext", m_wr_next, 0);
    check("rst_rvalid", m_rd_valid, 0);
    check("rst_wen", app_wr_en_n, {APP_BW{1'b1}});
    reset_n = 1'b1;

    // both masters from reset, writes of 4: m0 then m1
    config_master(0, 30'h100, 9'd4, 1'b0);
    config_master(1, 30'h200, 9'd4, 1'b0);
    expect_grant(0);
    expect_grant(1);
    post(0, 1);
    post(1, 1);
    serve(1'b0, 1'b0, -1);
    serve(1'b0, 1'b0, -1);

    // m0 holds request over three bursts, m1 asks once: m0,m1,m0,m0
    config_master(0, 30'h300, 9'd2, 1'b1);
    config_master(1, 30'h400, 9'd3, 1'b0);
    expect_grant(0);
    expect_grant(1);
    expect_grant(0);
    expect_grant(0);
    post(0, 3);
    post(1, 1);
    repeat (4) serve(1'b0, 1'b1, -1);

    // read of 8 with gaps and wrong-direction pulses
    config_master(0, 30'h500, 9'd8, 1'b1);
    expect_grant(0);
    post(0, 1);
    serve(1'b0, 1'b1, -1);

    // write of 4 with app_wr_next already high in the ack cycle
    config_master(1, 30'h600, 9'd4, 1'b0);
    expect_grant(1);
    post(1, 1);
    serve(1'b1, 1'b0, -1);

    // zero-length request, then rotation to m1
    config_master(0, 30'h700, 9'd0, 1'b0);
    config_master(1, 30'h800, 9'd2, 1'b1);
    expect_grant(0);
    expect_grant(1);
    post(0, 1);
    post(1, 1);
    serve(1'b0, 1'b0, -1);
    check("len0_gid", grant_id, 0);
    serve(1'b0, 1'b0, -1);

    // reset during a read burst
    config_master(0, 30'h900, 9'd8, 1'b1);
    expect_grant(0);
    post(0, 1);
    serve(1'b0, 1'b1, 3);

    repeat (3) @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
